// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read port (first-word-fall-through) between the FIFO and the UART transmitter
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd;
  logic                  empty;
  logic [DATA_WIDTH-1:0] r_data;
  modport master (output rd, input empty, input r_data);
  modport slave (input rd, output empty, output r_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops FIFO words and serialises them as UART frames; define PARITY_EN to add an even-parity bit
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_en,
  fifo_uart_tx_if.master      fifo,
  output logic                tx,
  output logic                tx_busy
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BMAX = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] SMAX = BW'(STOP_BITS - 1);
`ifdef PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [TW-1:0]         tick;
  logic [BW-1:0]         bit_cnt;
  assign fifo.rd = (state == IDLE) & tx_en & ~fifo.empty;
  // Frame sequencer: tick paces each bit, bit_cnt counts data bits and then stop bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      sreg    <= '0;
      tick    <= '0;
      bit_cnt <= '0;
`ifdef PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      tick <= (state == IDLE || tick == TMAX) ? '0 : tick + TW'(1);
      case (state)
        IDLE: if (fifo.rd) begin
          state   <= START;
          sreg    <= fifo.r_data;
          tx      <= 1'b0;
          tx_busy <= 1'b1;
`ifdef PARITY_EN
          par     <= ^fifo.r_data;
`endif
        end
        START: if (tick == TMAX) begin
          state   <= DATA;
          tx      <= sreg[0];
          bit_cnt <= '0;
        end
        DATA: if (tick == TMAX) begin
          if (bit_cnt == BMAX) begin
            bit_cnt <= '0;
`ifdef PARITY_EN
            state   <= PARITY;
            tx      <= par;
`else
            state   <= STOP;
            tx      <= 1'b1;
`endif
          end else begin
            sreg    <= sreg >> 1;
            tx      <= sreg[1];
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
`ifdef PARITY_EN
        PARITY: if (tick == TMAX) begin
          state   <= STOP;
          tx      <= 1'b1;
          bit_cnt <= '0;
        end
`endif
        STOP: if (tick == TMAX) begin
          if (bit_cnt == SMAX) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives fifo_uart_tx from a queue-based FIFO and checks it against a frame-level model
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef PARITY_EN
  localparam int P = 1;
  localparam logic [15:0] LIT05 = 16'b0000_0100_0000_1010;
  localparam int F_LIT = 44;
`else
  localparam int P = 0;
  localparam logic [15:0] LIT05 = 16'b0000_0010_0000_1010;
  localparam int F_LIT = 40;
`endif
  localparam int NB = 1 + 8 + P + 1;
  localparam int F  = NB * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_en = 1'b1;
  logic tx, tx_busy;
  logic wr = 1'b0;
  logic [7:0] wdata = '0;
  logic f_empty = 1'b1;
  logic [7:0] f_head = '0;
  logic [7:0] q[$];
  logic [7:0] sent_q[$];
  int rd_log[$];
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int m_cnt = 0;
  logic [15:0] m_bits = '1;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) bus ();
  assign bus.empty  = f_empty;
  assign bus.r_data = f_head;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo(bus), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.rd && q.size() > 0) void'(q.pop_front());
    if (wr && q.size() < 8) begin
      q.push_back(wdata);
      sent_q.push_back(wdata);
    end
    f_empty <= (q.size() == 0);
    f_head  <= (q.size() > 0) ? q[0] : 8'h00;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) m_cnt = 0;
    else if (m_cnt > 0) m_cnt = m_cnt - 1;
    else if (tx_en && !f_empty) begin
      if (sent_q.size() == 0) begin
        chk("model_word_available", 0, 1);
      end else begin
        logic [7:0] w;
        w = sent_q.pop_front();
        m_bits = '1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) m_bits[1+i] = w[i];
        if (P == 1) m_bits[9] = ^w;
        m_cnt = F;
      end
    end
  end

  always @(negedge clk) begin
    chk("tx", tx, (m_cnt == 0) ? 1'b1 : m_bits[(F - m_cnt) / CPB]);
    chk("tx_busy", tx_busy, m_cnt > 0);
    chk("rd", bus.rd, (m_cnt == 0) && tx_en && !f_empty);
    if (bus.rd) rd_log.push_back(cyc);
  end

  task automatic write_word(input logic [7:0] d);
    @(posedge clk); #1;
    wr = 1'b1;
    wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wait_rd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.rd;
    end
    chk("rd_timeout", ok, 1);
  endtask

  task automatic send_check(input logic [7:0] w, input logic [15:0] lit, input int busy_exp);
    int busy_cnt;
    bit ok;
    write_word(w);
    wait_rd(ok);
    busy_cnt = 0;
    for (int i = 1; i <= busy_exp + 4; i++) begin
      @(negedge clk);
      busy_cnt += int'(tx_busy);
      if (i % 4 == 2 && i / 4 < NB) chk($sformatf("lit_bit%0d", i / 4), tx, lit[i / 4]);
    end
    chk("busy_len", busy_cnt, busy_exp);
    chk("empty_after", f_empty, 1);
  endtask

  initial begin
    bit ok;
    int tx_low;
    repeat (3) begin
      @(negedge clk);
      chk("reset_rd", bus.rd, 0);
      chk("reset_tx", tx, 1);
      chk("reset_busy", tx_busy, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_no_rd", rd_log.size(), 0);

    send_check(8'h05, LIT05, F_LIT);

    rd_log.delete();
    foreach (sent_q[i]) chk("sent_q_clean", 1, 0);
    begin
      logic [7:0] burst [8] = '{8'd5, 8'd8, 8'd12, 8'd2, 8'd9, 8'd14, 8'd13, 8'd6};
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        wr = 1'b1;
        wdata = burst[i];
      end
      @(posedge clk); #1;
      wr = 1'b0;
    end
    repeat (8 * (F_LIT + 1) + 30) @(negedge clk);
    chk("burst_rd_count", rd_log.size(), 8);
    for (int i = 1; i < 8 && i < rd_log.size(); i++)
      chk($sformatf("burst_spacing%0d", i), rd_log[i] - rd_log[i-1], F_LIT + 1);
    chk("burst_empty", f_empty, 1);

    write_word(8'h0C);
    wait_rd(ok);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    rd_log.delete();
    tx_low = 0;
    repeat (50) begin
      @(negedge clk);
      tx_low += int'(!tx);
    end
    chk("after_reset_rd", rd_log.size(), 0);
    chk("after_reset_tx_low", tx_low, 0);

    @(posedge clk); #1;
    tx_en = 1'b0;
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    rd_log.delete();
    repeat (20) @(negedge clk);
    chk("hold_no_rd", rd_log.size(), 0);
    chk("hold_tx", tx, 1);
    @(posedge clk); #1;
    tx_en = 1'b1;
    #1;
    chk("en_rd_immediate", bus.rd, 1);
    repeat (20) @(negedge clk);
    #2 tx_en = 1'b0;
    repeat (100) @(negedge clk);
    chk("drop_rd_count", rd_log.size(), 1);
    chk("drop_queue_left", q.size(), 2);
    chk("drop_idle_tx", tx, 1);
    @(posedge clk); #1;
    tx_en = 1'b1;
    repeat (2 * (F_LIT + 1) + 10) @(negedge clk);
    chk("drain_rd_count", rd_log.size(), 3);
    chk("drain_empty", f_empty, 1);

`ifdef PARITY_EN
    send_check(8'h07, 16'b0000_0110_0000_1110, 44);
    send_check(8'h05, 16'b0000_0100_0000_1010, 44);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
